// File: rtl/bus_xfer_sequencer_if.sv
// Command handshake and register-pin bundle for the bus transfer sequencer.
// The master side offers commands; the slave side drives the register pins.
interface bus_xfer_sequencer_if #(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = $clog2(NUM_REGS + 1)
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_op;
    logic [SEL_W-1:0]    cmd_src;
    logic [SEL_W-1:0]    cmd_dst;
    logic [NUM_REGS-1:0] oe_n;
    logic [NUM_REGS-1:0] en_n;
    logic [NUM_REGS-1:0] clr_n;
    logic                ext_oe_n;
    logic                bus_busy;
    logic                done;
    logic                err;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst,
        input  cmd_ready, oe_n, en_n, clr_n,
        input  ext_oe_n, bus_busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst,
        output cmd_ready, oe_n, en_n, clr_n,
        output ext_oe_n, bus_busy, done, err
    );
endinterface

// File: rtl/bus_xfer_sequencer.sv
// Sequences register moves and clears on a shared 3-state bus.
// Every pin is registered from the next state so enables never glitch.
module bus_xfer_sequencer #(
    parameter int NUM_REGS    = 4,
    parameter int DEAD_CYCLES = 1,
    parameter int SEL_W       = $clog2(NUM_REGS + 1)
) (
    input  logic clk,
    input  logic rst,
    bus_xfer_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, DRIVE, CAPTURE, RELEASE, CLEAR
    } state_t;

    localparam logic [SEL_W-1:0] EXT = SEL_W'(NUM_REGS);
    localparam logic [2:0] CNT_INIT = 3'(DEAD_CYCLES - 1);

    state_t state_q, state_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [SEL_W-1:0] dst_q, dst_d;
    logic [2:0] cnt_q, cnt_d;

    logic [NUM_REGS-1:0] oe_q, oe_d;
    logic [NUM_REGS-1:0] en_q, en_d;
    logic [NUM_REGS-1:0] clr_q, clr_d;
    logic ext_q, ext_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic ready_q, ready_d;

    logic accept;
    logic bad;

    assign accept = (state_q == IDLE) && bus.cmd_valid;
    assign bad = (bus.cmd_dst >= EXT) ||
                 (!bus.cmd_op &&
                  ((bus.cmd_src > EXT) ||
                   (bus.cmd_src == bus.cmd_dst)));

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        src_d   = bus.cmd_src;
                        dst_d   = bus.cmd_dst;
                        state_d = bus.cmd_op ? CLEAR : DRIVE;
                    end
                end
            end
            DRIVE: state_d = CAPTURE;
            CAPTURE: begin
                state_d = RELEASE;
                cnt_d   = CNT_INIT;
            end
            RELEASE: begin
                if (cnt_q == 3'd0) state_d = IDLE;
                else               cnt_d = cnt_q - 3'd1;
            end
            CLEAR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin values are derived from where the FSM is going, then registered.
    always_comb begin
        oe_d   = '1;
        en_d   = '1;
        clr_d  = '1;
        ext_d  = 1'b1;
        done_d = 1'b0;
        unique case (state_d)
            DRIVE, CAPTURE: begin
                if (src_d == EXT) ext_d = 1'b0;
                else oe_d = ~(NUM_REGS'(1) << src_d);
                if (state_d == CAPTURE)
                    en_d = ~(NUM_REGS'(1) << dst_d);
            end
            RELEASE: done_d = (cnt_d == 3'd0);
            CLEAR: begin
                clr_d  = ~(NUM_REGS'(1) << dst_d);
                done_d = 1'b1;
            end
            default: ;
        endcase
        busy_d  = ~&oe_d | ~ext_d;
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            oe_q    <= '1;
            en_q    <= '1;
            clr_q   <= '1;
            ext_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            oe_q    <= oe_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            ext_q   <= ext_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.oe_n      = oe_q;
    assign bus.en_n      = en_q;
    assign bus.clr_n     = clr_q;
    assign bus.ext_oe_n  = ext_q;
    assign bus.bus_busy  = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
